// File: rtl/pipelined_control_unit.sv
// ID-stage decode controller for the 5-stage RV32I pipeline: registers control bits into
// ID/EX, inserts bubbles on flush / load-use hazards, flags bad opcodes and drains on HALT.
module pipelined_control_unit #(
  parameter int OPCODE_W     = 7,
  parameter int REG_ADDR_W   = 5,
  parameter int ALUOP_W      = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   Opcode,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  flush,
  input  logic                  resume,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_ALUSrc,
  output logic                  ex_MemtoReg,
  output logic                  ex_RegWrite,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_Branch,
  output logic                  ex_Jal,
  output logic [ALUOP_W-1:0]    ex_ALUOp,
  output logic                  ex_valid,
  output logic                  ex_illegal,
  output logic                  stall,
  output logic                  halted
);
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(7'b1111111);

  typedef struct packed {
    logic               alusrc;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic               jal;
    logic               illegal;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  ctrl_t            ctrl_p0, ctrl_p1;
  logic             vld_p1;
  logic             load_use, issue, take_halt;

  function automatic ctrl_t decode(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    logic  r, i, lw, sw, br, jal, jalr, hlt;
    c    = '0;
    r    = (op == OP_R);
    i    = (op == OP_I);
    lw   = (op == OP_LW);
    sw   = (op == OP_SW);
    br   = (op == OP_BR);
    jal  = (op == OP_JAL);
    jalr = (op == OP_JALR);
    hlt  = (op == OP_HALT);
    c.alusrc   = lw | sw | i | jalr;
    c.memtoreg = lw;
    c.memread  = lw;
    c.regwrite = r | lw | i | jal | jalr;
    c.memwrite = sw;
    c.branch   = br | jal | jalr | hlt;
    c.jal      = jal;
    c.aluop[0] = br | jalr;
    c.aluop[1] = r | i | jalr;
    c.illegal  = ~(r | i | lw | sw | br | jal | jalr | hlt);
    return c;
  endfunction

  assign ctrl_p0   = decode(Opcode);
  assign load_use  = id_valid & vld_p1 & ctrl_p1.memread & (ex_rd != '0)
                   & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign issue     = (state == RUN) & id_valid & ~flush & ~load_use;
  assign take_halt = issue & (Opcode == OP_HALT);

  // ID -> EX boundary: anything that does not issue becomes a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (issue) begin
      ctrl_p1 <= ctrl_p0;
      vld_p1  <= 1'b1;
    end else begin
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (take_halt)
        cnt <= CNT_W'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (take_halt) state_next = DRAIN;
      DRAIN:   if (cnt == '0) state_next = HALTED;
      HALTED:  if (resume)    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Only RUN lets the front end advance; DRAIN and HALTED freeze PC and IF/ID
  always_comb begin
    stall  = 1'b1;
    halted = 1'b0;
    case (state)
      RUN:     stall  = load_use & ~flush;
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

  assign ex_ALUSrc   = ctrl_p1.alusrc;
  assign ex_MemtoReg = ctrl_p1.memtoreg;
  assign ex_RegWrite = ctrl_p1.regwrite;
  assign ex_MemRead  = ctrl_p1.memread;
  assign ex_MemWrite = ctrl_p1.memwrite;
  assign ex_Branch   = ctrl_p1.branch;
  assign ex_Jal      = ctrl_p1.jal;
  assign ex_ALUOp    = ctrl_p1.aluop;
  assign ex_illegal  = ctrl_p1.illegal;
  assign ex_valid    = vld_p1;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: directed corner cases plus random traffic
// checked against a table-level model of decode, hazards and the halt/drain sequence.
module tb_pipelined_control_unit;
  localparam int DRAIN_CYCLES = 3;
  localparam logic [6:0] R = 7'h33, I = 7'h13, LW = 7'h03, SW = 7'h23, BR = 7'h63,
                         JAL = 7'h6F, JALR = 7'h67, HALT = 7'h7F, BAD = 7'h0B;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] Opcode = '0;
  logic       id_valid = 1'b0, flush = 1'b0, resume = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jal;
  logic [1:0] ex_ALUOp;
  logic       ex_valid, ex_illegal, stall, halted;
  logic [11:0] dut_vec;

  int total = 0, bad = 0;
  logic [11:0] expq[$];
  bit mon_en = 1'b0;

  // model state: 0 = running, 1 = draining, 2 = halted
  int m_mode = 0, m_drain = 0;
  bit m_valid = 1'b0, m_memread = 1'b0;

  pipelined_control_unit #(.OPCODE_W(7), .REG_ADDR_W(5), .ALUOP_W(2), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .flush(flush), .resume(resume), .ex_rd(ex_rd),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_Jal(ex_Jal),
    .ex_ALUOp(ex_ALUOp), .ex_valid(ex_valid), .ex_illegal(ex_illegal), .stall(stall),
    .halted(halted));

  always #5 clk = ~clk;

  assign dut_vec = {halted, ex_valid, ex_illegal, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
                    ex_MemRead, ex_MemWrite, ex_Branch, ex_Jal, ex_ALUOp};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {illegal, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jal, ALUOp[1:0]}
  function automatic logic [9:0] model_decode(input logic [6:0] op);
    bit r, i, lw, sw, br, jal, jalr, hlt;
    r = (op == R); i = (op == I); lw = (op == LW); sw = (op == SW);
    br = (op == BR); jal = (op == JAL); jalr = (op == JALR); hlt = (op == HALT);
    return {!(r | i | lw | sw | br | jal | jalr | hlt), lw | sw | i | jalr, lw,
            r | lw | i | jal | jalr, lw, sw, br | jal | jalr | hlt, jal, r | i | jalr, br | jalr};
  endfunction

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (expq.size() == 0) chk("queue_underflow", 32'd1, 32'd0);
      else chk("ex_ctrl", {20'd0, dut_vec}, {20'd0, expq.pop_front()});
    end
  end

  task automatic step(input logic [6:0] op, input bit vld, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit fl, input bit rs, input logic [4:0] rd);
    bit lu, take, st;
    logic [9:0] d;
    @(negedge clk);
    Opcode = op; id_valid = vld; id_rs1 = rs1; id_rs2 = rs2; flush = fl; resume = rs; ex_rd = rd;
    lu = vld && m_valid && m_memread && rd != 0 && (rd == rs1 || rd == rs2);
    st = (m_mode == 0) ? (lu && !fl) : 1'b1;
    #1 chk("stall", {31'd0, stall}, {31'd0, st});
    take = !fl && !lu && m_mode == 0 && vld;
    d = take ? model_decode(op) : 10'd0;
    case (m_mode)
      0: if (take && op == HALT) begin m_mode = 1; m_drain = 0; end
      1: begin m_drain++; if (m_drain == DRAIN_CYCLES) m_mode = 2; end
      default: if (rs) m_mode = 0;
    endcase
    m_valid = take;
    m_memread = d[5];
    expq.push_back({m_mode == 2, take, d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b0; flush = 1'b0; resume = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Opcode = 7'($urandom); id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd1; ex_rd = 5'd1;
      #1 chk("reset_outputs", {20'd0, dut_vec}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
    end
    reset = 1'b1; Opcode = LW; id_valid = 1'b0;
    #1 chk("release_outputs", {20'd0, dut_vec}, 32'd0);
    expq.delete();
    m_mode = 0; m_drain = 0; m_valid = 1'b0; m_memread = 1'b0;
    expq.push_back(12'd0);
    mon_en = 1'b1;
  endtask

  initial begin
    logic [6:0] ops[10];
    ops = '{R, I, LW, SW, BR, JAL, JALR, HALT, BAD, 7'h00};
    do_reset();
    // decode sweep (HALT last is exercised separately below)
    for (int k = 0; k < 7; k++) step(ops[k], 1, 0, 0, 0, 0, 0);
    step(BAD, 1, 0, 0, 0, 0, 0);
    step(7'h5B, 1, 0, 0, 0, 0, 0);
    // load-use: one stall then the add issues; rd = x0 never stalls
    step(LW, 1, 1, 2, 0, 0, 0);
    step(R, 1, 0, 5, 0, 0, 5);
    step(R, 1, 0, 5, 0, 0, 5);
    step(LW, 1, 1, 2, 0, 0, 0);
    step(R, 1, 0, 0, 0, 0, 0);
    // flush beats load-use
    step(LW, 1, 1, 2, 0, 0, 0);
    step(R, 1, 5, 0, 1, 0, 5);
    // HALT under flush is not a halt
    step(HALT, 1, 0, 0, 1, 0, 0);
    step(R, 1, 0, 0, 0, 0, 0);
    // HALT behind a load-use waits, then drains; resume on the final drain edge is ignored
    step(LW, 1, 1, 2, 0, 0, 0);
    step(HALT, 1, 5, 0, 0, 0, 5);
    step(HALT, 1, 0, 0, 0, 0, 5);
    step(R, 1, 0, 0, 1, 0, 0);
    step(R, 1, 0, 0, 0, 0, 0);
    step(R, 1, 0, 0, 0, 1, 0);
    step(R, 1, 0, 0, 0, 0, 0);
    step(R, 1, 0, 0, 0, 1, 0);
    step(R, 1, 0, 0, 0, 0, 0);
    // reset mid-drain
    step(HALT, 1, 0, 0, 0, 0, 0);
    step(R, 1, 0, 0, 0, 0, 0);
    do_reset();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      step((n % 7 == 6) ? 7'($urandom) : ops[$urandom_range(0, 9)],
           $urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("queue_drained", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
